pll_reset_sequencer: RTL and testbench

//  Drives the PLL's RST input and consumes its LOCKED output. Sits between the board reset and the PLL wrapper.
//  - Holds the PLL in reset for a minimum time, then waits for lock with a timeout.
//  - Retries a bounded number of times; requires stable lock before releasing the downstream system reset (SYS_RST).
//  - Any lock loss while running restarts the full sequence.
//  - Runs on the free-running PLL input clock.

---
 rtl/pll_reset_sequencer.sv | 155 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Drives the PLL reset and watches its lock output. Each attempt holds
//   PLL_RST for a minimum time and then waits, with a timeout, for lock. It
//   retries a bounded number of times before entering a terminal FAIL state.
//   Lock must stay stable for a set time before the downstream reset is
//   released. Any loss of lock after that point restarts the whole sequence.
//   The block runs on the free-running PLL input clock.
//
// Ports
//   CLKIN1        in   free-running reference clock (PLL input clock)
//   RST           in   synchronous active-high reset
//   LOCKED        in   PLL lock, asynchronous; two-flop synchronised internally
//   PLL_RST       out  reset to the PLL, high in HOLD and FAIL
//   SYS_RST       out  downstream reset, low only in RUN
//   READY         out  high only in RUN
//   FAIL          out  high only in FAIL
//   RETRY_CNT     out  retries consumed in the current sequence
//   LOCK_LOSS_CNT out  lock-loss events from RELEASE/RUN, saturating at 255
//   STATE         out  HOLD=0 WAIT_LOCK=1 STABLE=2 RELEASE=3 RUN=4 FAIL=5
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES   = 256,
  parameter int unsigned RELEASE_DELAY_CYCLES = 64,
  parameter int unsigned MAX_RETRIES          = 7,
  parameter int unsigned CNT_W                = 17
) (
  input  logic       CLKIN1,
  input  logic       RST,
  input  logic       LOCKED,
  output logic       PLL_RST,
  output logic       SYS_RST,
  output logic       READY,
  output logic       FAIL,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] LOCK_LOSS_CNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] L_HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_RELEASE_LAST = CNT_W'(RELEASE_DELAY_CYCLES - 1);
  localparam logic [3:0]       L_MAX_RETRIES  = 4'(MAX_RETRIES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retry;
  logic [7:0]       r_llc;
  logic             r_lock_meta;
  logic             r_lock_s;

  state_t           w_state_nxt;
  logic             w_retry_inc;
  logic             w_retry_clr;
  logic             w_lock_loss;

  // LOCKED is asynchronous to CLKIN1; only r_lock_s is used by the FSM.
  always_ff @(posedge CLKIN1) begin
    if (RST) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= LOCKED;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_lock_loss = 1'b0;
    case (r_state)
      S_HOLD: begin
        if (r_cnt == L_HOLD_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock seen in the timeout cycle still wins over the retry.
        if (r_lock_s) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == L_TIMEOUT_LAST) begin
          if (r_retry < L_MAX_RETRIES) begin
            w_retry_inc = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_FAIL;
          end
        end
      end
      S_STABLE: begin
        if (!r_lock_s)                   w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == L_STABLE_LAST) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!r_lock_s) begin
          w_state_nxt = S_HOLD;
          w_lock_loss = 1'b1;
        end else if (r_cnt == L_RELEASE_LAST) begin
          w_state_nxt = S_RUN;
          w_retry_clr = 1'b1;
        end
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = S_HOLD;
          w_lock_loss = 1'b1;
        end
      end
      S_FAIL: begin
        w_state_nxt = S_FAIL;
      end
      default: begin
        w_state_nxt = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge CLKIN1) begin
    if (RST) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_retry <= '0;
      r_llc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Every state transition restarts the shared counter at zero.
      if (w_state_nxt != r_state) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 1'b1;
      if (w_retry_clr)      r_retry <= '0;
      else if (w_retry_inc) r_retry <= r_retry + 1'b1;
      if (w_lock_loss && (r_llc != 8'hFF)) r_llc <= r_llc + 1'b1;
    end
  end

  always_comb begin
    PLL_RST       = (r_state == S_HOLD) || (r_state == S_FAIL);
    SYS_RST       = (r_state != S_RUN);
    READY         = (r_state == S_RUN);
    FAIL          = (r_state == S_FAIL);
    RETRY_CNT     = r_retry;
    LOCK_LOSS_CNT = r_llc;
    STATE         = r_state;
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Bench for pll_reset_sequencer with small timing parameters. Each cycle
//   the expected state/outputs/counters are pushed to a scoreboard queue and
//   popped when the DUT outputs are sampled on the falling clock edge.
module tb_pll_reset_sequencer;

  localparam logic [2:0] HOLD = 3'd0, WAIT = 3'd1, STAB = 3'd2,
                         RELS = 3'd3, RUN  = 3'd4, FAILS = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .RELEASE_DELAY_CYCLES(4),
    .MAX_RETRIES         (2),
    .CNT_W               (6)
  ) dut (
    .CLKIN1       (clk),
    .RST          (rst),
    .LOCKED       (locked),
    .PLL_RST      (pll_rst),
    .SYS_RST      (sys_rst),
    .READY        (ready),
    .FAIL         (fail),
    .RETRY_CNT    (retry_cnt),
    .LOCK_LOSS_CNT(lock_loss_cnt),
    .STATE        (state)
  );

  typedef struct {
    string       tag;
    logic [18:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_llc  = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {STATE, PLL_RST, SYS_RST, READY, FAIL, RETRY_CNT, LOCK_LOSS_CNT}
  function automatic logic [18:0] pack_exp(input logic [2:0] st, input logic [3:0] rc,
                                           input logic [7:0] llc);
    return {st, (st == HOLD) || (st == FAILS), st != RUN, st == RUN, st == FAILS, rc, llc};
  endfunction

  task automatic obs(input string tag, input logic [2:0] st, input logic [3:0] rc,
                     input logic [7:0] llc);
    sb_t e;
    e.tag = tag;
    e.exp = pack_exp(st, rc, llc);
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check(e.tag,
          {13'd0, state, pll_rst, sys_rst, ready, fail, retry_cnt, lock_loss_cnt},
          {13'd0, e.exp});
  endtask

  task automatic expect_n(input string tag, input logic [2:0] st, input int unsigned n,
                          input logic [3:0] rc);
    for (int unsigned i = 0; i < n; i++) obs(tag, st, rc, exp_llc);
  endtask

  // One reset edge; the sample after it is cycle 0 (HOLD, counters zero).
  task automatic do_reset(input string tag);
    rst = 1'b1;
    exp_llc = 8'd0;
    obs(tag, HOLD, 4'd0, 8'd0);
    rst = 1'b0;
  endtask

  // Called right after sampling a RUN cycle: LOCKED low for two cycles.
  // With relock, expect a full resequence back into RUN.
  task automatic lose_lock(input string tag, input bit relock);
    locked = 1'b0;
    obs({tag, "_run0"}, RUN, 4'd0, exp_llc);
    if (relock) locked = 1'b1;
    obs({tag, "_run1"}, RUN, 4'd0, exp_llc);
    if (exp_llc != 8'hFF) exp_llc = exp_llc + 8'd1;
    expect_n({tag, "_hold"}, HOLD, 4, 4'd0);
    if (relock) begin
      expect_n({tag, "_wait"}, WAIT, 1, 4'd0);
      expect_n({tag, "_stab"}, STAB, 8, 4'd0);
      expect_n({tag, "_rels"}, RELS, 4, 4'd0);
      expect_n({tag, "_run"},  RUN,  1, 4'd0);
    end else begin
      expect_n({tag, "_wait"}, WAIT, 5, 4'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Happy path: LOCKED high throughout.
    locked = 1'b1;
    do_reset("s1_reset");
    expect_n("s1_hold", HOLD, 3, 4'd0);
    expect_n("s1_wait", WAIT, 1, 4'd0);
    expect_n("s1_stab", STAB, 8, 4'd0);
    expect_n("s1_rels", RELS, 4, 4'd0);
    expect_n("s1_run",  RUN,  4, 4'd0);

    // Lock loss in RUN, then enough further losses to saturate the counter.
    lose_lock("s4", 1'b1);
    for (int i = 0; i < 256; i++) lose_lock("s5", 1'b1);
    check("s5_llc_sat", {24'd0, lock_loss_cnt}, 32'd255);

    // Permanent lock loss, then RST while in WAIT_LOCK.
    lose_lock("s6a", 1'b0);
    do_reset("s6_rst_wait");

    // No lock: three attempts, then FAIL until RST.
    expect_n("s2_hold0", HOLD,  3,  4'd0);
    expect_n("s2_wait0", WAIT,  32, 4'd0);
    expect_n("s2_hold1", HOLD,  4,  4'd1);
    expect_n("s2_wait1", WAIT,  32, 4'd1);
    expect_n("s2_hold2", HOLD,  4,  4'd2);
    expect_n("s2_wait2", WAIT,  32, 4'd2);
    expect_n("s2_fail",  FAILS, 10, 4'd2);
    do_reset("s6_rst_fail");

    // One retry, lock in the second attempt, one-cycle glitch during STABLE.
    expect_n("s3_hold0", HOLD, 3,  4'd0);
    expect_n("s3_wait0", WAIT, 32, 4'd0);
    expect_n("s3_hold1", HOLD, 4,  4'd1);
    locked = 1'b1;
    expect_n("s3_wait1", WAIT, 2,  4'd1);
    expect_n("s3_stab0", STAB, 2,  4'd1);
    locked = 1'b0;
    expect_n("s3_stab1", STAB, 1,  4'd1);
    locked = 1'b1;
    expect_n("s3_stab2", STAB, 1,  4'd1);
    expect_n("s3_rewait", WAIT, 1, 4'd1);
    expect_n("s3_stab3", STAB, 8,  4'd1);
    expect_n("s3_rels",  RELS, 4,  4'd1);
    expect_n("s3_run",   RUN,  3,  4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
